// File: rtl/pcileech_sysctl_pkg.sv
// System control sequencer package: FSM state encoding and default timing constants.
package pcileech_sysctl_pkg;

  typedef enum logic [2:0] {
    S_RESET    = 3'd0,
    S_REL_COM  = 3'd1,
    S_REL_FIFO = 3'd2,
    S_RUN      = 3'd3,
    S_HELD     = 3'd4
  } sysctl_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES  = 1000000;
  localparam int unsigned DEF_RST_HOLD_CYCLES  = 64;
  localparam int unsigned DEF_STAGE_GAP_CYCLES = 16;
  localparam int unsigned DEF_LONGPRESS_CYCLES = 500000000;  // 5 s at 100 MHz
  localparam int unsigned DEF_BLINK_BIT        = 24;
  localparam int unsigned DEF_BLINK_WINDOW_BIT = 27;

endpackage

// File: rtl/pcileech_btn_debounce.sv
// Button conditioner: 2-flop synchronizer followed by a debounce counter.
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset (holds the button "released")
//   btn_raw_n    raw asynchronous button, active low
//   btn_pressed  debounced button state, active high
module pcileech_btn_debounce
  import pcileech_sysctl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_n,
  output logic btn_pressed
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic            sync1_q, sync2_q;
  logic            pressed_q, pressed_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sample_pressed;

  assign sample_pressed = ~sync2_q;

  // Count consecutive samples that disagree with the debounced state; any agreeing
  // sample restarts the count.
  always_comb begin
    pressed_d = pressed_q;
    cnt_d     = '0;
    if (sample_pressed != pressed_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        pressed_d = sample_pressed;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      pressed_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= btn_raw_n;
      sync2_q   <= sync1_q;
      pressed_q <= pressed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign btn_pressed = pressed_q;

endmodule

// File: rtl/pcileech_sysctl_seq.sv
// System reset/button sequencer. Releases staged resets COM -> FIFO -> PCIe, holds all
// resets while the reset button is pressed, pulses cfg_reload on a long press and
// drives the power-on LED blink.
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   user_sw_rst_n    raw reset button (async, active low)
//   user_sw_led_n    raw LED-invert button (async, active low)
//   rst_com/fifo/pcie active-high staged resets
//   cfg_reload       single-cycle config reload request
//   led_pwronblink   LED invert/blink level
//   seq_ready        high only in S_RUN
//   seq_state        current FSM state (debug)
module pcileech_sysctl_seq
  import pcileech_sysctl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned RST_HOLD_CYCLES  = DEF_RST_HOLD_CYCLES,
  parameter int unsigned STAGE_GAP_CYCLES = DEF_STAGE_GAP_CYCLES,
  parameter int unsigned LONGPRESS_CYCLES = DEF_LONGPRESS_CYCLES,
  parameter int unsigned BLINK_BIT        = DEF_BLINK_BIT,
  parameter int unsigned BLINK_WINDOW_BIT = DEF_BLINK_WINDOW_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       user_sw_rst_n,
  input  logic       user_sw_led_n,
  output logic       rst_com,
  output logic       rst_fifo,
  output logic       rst_pcie,
  output logic       cfg_reload,
  output logic       led_pwronblink,
  output logic       seq_ready,
  output logic [2:0] seq_state
);

  localparam int unsigned StageMax = (RST_HOLD_CYCLES > STAGE_GAP_CYCLES) ?
                                     RST_HOLD_CYCLES : STAGE_GAP_CYCLES;
  localparam int unsigned CntW  = $clog2(StageMax) + 1;
  localparam int unsigned HoldW = $clog2(LONGPRESS_CYCLES) + 1;
  localparam int unsigned UpW   = BLINK_WINDOW_BIT + 1;

  logic sw_rst_pressed, sw_led_pressed;

  pcileech_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_rst (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw_n  (user_sw_rst_n),
    .btn_pressed(sw_rst_pressed)
  );

  pcileech_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_led (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw_n  (user_sw_led_n),
    .btn_pressed(sw_led_pressed)
  );

  sysctl_state_t    state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [UpW-1:0]   uptime_q, uptime_d;
  logic             cfg_d, led_d;
  logic             rst_com_q, rst_fifo_q, rst_pcie_q, cfg_q, led_q, ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    hold_d  = hold_q;
    cfg_d   = 1'b0;
    unique case (state_q)
      S_RESET: begin
        if (cnt_q == CntW'(RST_HOLD_CYCLES - 1)) begin
          state_d = S_REL_COM;
          cnt_d   = '0;
        end
      end
      S_REL_COM: begin
        if (cnt_q == CntW'(STAGE_GAP_CYCLES - 1)) begin
          state_d = S_REL_FIFO;
          cnt_d   = '0;
        end
      end
      S_REL_FIFO: begin
        if (cnt_q == CntW'(STAGE_GAP_CYCLES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = '0;
      end
      S_HELD: begin
        cnt_d = '0;
        // hold_q saturates at LONGPRESS_CYCLES, so the terminal compare matches once.
        if (hold_q != HoldW'(LONGPRESS_CYCLES)) begin
          hold_d = hold_q + 1'b1;
        end
        if (sw_rst_pressed && hold_q == HoldW'(LONGPRESS_CYCLES - 1)) begin
          cfg_d = 1'b1;
        end
        if (!sw_rst_pressed) begin
          state_d = S_RESET;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = S_RESET;
        cnt_d   = '0;
      end
    endcase
    // A press wins over any stage transition due this cycle.
    if (sw_rst_pressed && state_q != S_HELD) begin
      state_d = S_HELD;
      cnt_d   = '0;
      hold_d  = '0;
    end
  end

  always_comb begin
    uptime_d = uptime_q;
    if (state_d == S_HELD) begin
      uptime_d = '0;
    end else if (!uptime_q[BLINK_WINDOW_BIT]) begin
      uptime_d = uptime_q + 1'b1;
    end
    led_d = sw_led_pressed ^ (uptime_q[BLINK_BIT] & ~uptime_q[BLINK_WINDOW_BIT]);
  end

  // Outputs are registered from the next state so they change on the same edge as it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_RESET;
      cnt_q      <= '0;
      hold_q     <= '0;
      uptime_q   <= '0;
      rst_com_q  <= 1'b1;
      rst_fifo_q <= 1'b1;
      rst_pcie_q <= 1'b1;
      cfg_q      <= 1'b0;
      led_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      uptime_q   <= uptime_d;
      rst_com_q  <= (state_d == S_RESET) || (state_d == S_HELD);
      rst_fifo_q <= (state_d == S_RESET) || (state_d == S_HELD) || (state_d == S_REL_COM);
      rst_pcie_q <= (state_d != S_RUN);
      cfg_q      <= cfg_d;
      led_q      <= led_d;
      ready_q    <= (state_d == S_RUN);
    end
  end

  assign rst_com        = rst_com_q;
  assign rst_fifo       = rst_fifo_q;
  assign rst_pcie       = rst_pcie_q;
  assign cfg_reload     = cfg_q;
  assign led_pwronblink = led_q;
  assign seq_ready      = ready_q;
  assign seq_state      = state_q;

endmodule

// File: tb/tb_pcileech_sysctl_seq.sv
// Directed bench for pcileech_sysctl_seq with small timing parameters.
module tb_pcileech_sysctl_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       user_sw_rst_n;
  logic       user_sw_led_n;
  logic       rst_com, rst_fifo, rst_pcie, cfg_reload, led_pwronblink, seq_ready;
  logic [2:0] seq_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cfg_pulses = 0;

  pcileech_sysctl_seq #(
    .DEBOUNCE_CYCLES (4),
    .RST_HOLD_CYCLES (8),
    .STAGE_GAP_CYCLES(4),
    .LONGPRESS_CYCLES(20),
    .BLINK_BIT       (2),
    .BLINK_WINDOW_BIT(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .user_sw_rst_n (user_sw_rst_n),
    .user_sw_led_n (user_sw_led_n),
    .rst_com       (rst_com),
    .rst_fifo      (rst_fifo),
    .rst_pcie      (rst_pcie),
    .cfg_reload    (cfg_reload),
    .led_pwronblink(led_pwronblink),
    .seq_ready     (seq_ready),
    .seq_state     (seq_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cfg_reload === 1'b1) cfg_pulses++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Blink level for a given uptime value (uptime saturates at 16).
  function automatic logic blink_exp(input int u);
    int v;
    v = (u > 16) ? 16 : u;
    return ((v >> 2) & 1) == 1 && ((v >> 4) & 1) == 0;
  endfunction

  initial begin
    rst_n         = 1'b0;
    user_sw_rst_n = 1'b1;
    user_sw_led_n = 1'b1;
    step(3);
    check("reset_state", {29'd0, seq_state}, 32'd0);
    check("reset_rsts", {29'd0, rst_com, rst_fifo, rst_pcie}, 32'b111);
    check("reset_ready", {31'd0, seq_ready}, 32'd0);
    check("reset_cfg", {31'd0, cfg_reload}, 32'd0);
    check("reset_led", {31'd0, led_pwronblink}, 32'd0);
    rst_n = 1'b1;

    // Power-on sequence and blink: after edge k, led reflects uptime k-1.
    for (int k = 1; k <= 24; k++) begin
      step(1);
      check("pwr_rst_com", {31'd0, rst_com}, {31'd0, k < 8});
      check("pwr_rst_fifo", {31'd0, rst_fifo}, {31'd0, k < 12});
      check("pwr_rst_pcie", {31'd0, rst_pcie}, {31'd0, k < 16});
      check("pwr_ready", {31'd0, seq_ready}, {31'd0, k >= 16});
      check("pwr_state", {29'd0, seq_state},
            (k < 8) ? 32'd0 : (k < 12) ? 32'd1 : (k < 16) ? 32'd2 : 32'd3);
      check("pwr_led", {31'd0, led_pwronblink}, {31'd0, blink_exp(k - 1)});
    end
    check("pwr_no_cfg", cfg_pulses, 0);

    // LED button inverts the (now constant 0) blink level.
    user_sw_led_n = 1'b0;
    step(6);
    check("led_press_early", {31'd0, led_pwronblink}, 32'd0);
    step(1);
    check("led_press", {31'd0, led_pwronblink}, 32'd1);
    user_sw_led_n = 1'b1;
    step(6);
    check("led_release_early", {31'd0, led_pwronblink}, 32'd1);
    step(1);
    check("led_release", {31'd0, led_pwronblink}, 32'd0);

    // 3-cycle glitch on the reset button is filtered.
    user_sw_rst_n = 1'b0;
    step(3);
    user_sw_rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("glitch_state", {29'd0, seq_state}, 32'd3);
      check("glitch_rst_com", {31'd0, rst_com}, 32'd0);
    end

    // Short press: resets assert, then the full release sequence replays.
    user_sw_rst_n = 1'b0;
    step(6);
    check("press_early_state", {29'd0, seq_state}, 32'd3);
    step(1);
    check("press_state", {29'd0, seq_state}, 32'd4);
    check("press_rsts", {29'd0, rst_com, rst_fifo, rst_pcie}, 32'b111);
    check("press_ready", {31'd0, seq_ready}, 32'd0);
    step(5);
    user_sw_rst_n = 1'b1;
    step(6);
    check("rel_early_state", {29'd0, seq_state}, 32'd4);
    step(1);
    check("rel_state", {29'd0, seq_state}, 32'd0);
    step(7);
    check("replay_com_hold", {31'd0, rst_com}, 32'd1);
    step(1);
    check("replay_com", {29'd0, rst_com, rst_fifo, rst_pcie}, 32'b011);
    step(4);
    check("replay_fifo", {29'd0, rst_com, rst_fifo, rst_pcie}, 32'b001);
    step(4);
    check("replay_pcie", {29'd0, rst_com, rst_fifo, rst_pcie}, 32'b000);
    check("replay_ready", {31'd0, seq_ready}, 32'd1);
    check("short_no_cfg", cfg_pulses, 0);

    // Long press: one cfg_reload pulse 20 cycles after entering S_HELD.
    user_sw_rst_n = 1'b0;
    step(7);
    check("long_state", {29'd0, seq_state}, 32'd4);
    step(19);
    check("long_cfg_before", {31'd0, cfg_reload}, 32'd0);
    step(1);
    check("long_cfg_pulse", {31'd0, cfg_reload}, 32'd1);
    step(1);
    check("long_cfg_after", {31'd0, cfg_reload}, 32'd0);
    step(12);
    user_sw_rst_n = 1'b1;
    step(7);
    check("long_rel_state", {29'd0, seq_state}, 32'd0);
    step(16);
    check("long_replay_state", {29'd0, seq_state}, 32'd3);
    check("long_one_pulse", cfg_pulses, 1);

    // rst_n mid-S_REL_FIFO.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(13);
    check("abort_fifo_pre", {29'd0, seq_state}, 32'd2);
    rst_n = 1'b0;
    step(1);
    check("abort_fifo_state", {29'd0, seq_state}, 32'd0);
    check("abort_fifo_rsts", {29'd0, rst_com, rst_fifo, rst_pcie}, 32'b111);
    rst_n = 1'b1;
    step(16);
    check("abort_fifo_run", {29'd0, seq_state}, 32'd3);

    // rst_n 10 cycles into S_HELD: no cfg_reload afterwards.
    user_sw_rst_n = 1'b0;
    step(7);
    check("abort_held_pre", {29'd0, seq_state}, 32'd4);
    step(10);
    rst_n         = 1'b0;
    user_sw_rst_n = 1'b1;
    step(1);
    check("abort_held_state", {29'd0, seq_state}, 32'd0);
    check("abort_held_rsts", {29'd0, rst_com, rst_fifo, rst_pcie}, 32'b111);
    check("abort_held_cfg", {31'd0, cfg_reload}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(25);
    check("abort_held_run", {29'd0, seq_state}, 32'd3);
    check("abort_no_cfg", cfg_pulses, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
